// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch_stage (master) and imem (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, keeps one imem request in flight and queues returned words.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect target halts fetch and sets misalign_o.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [31:0]   pc_o,
  output logic [31:0]   inst_o,
  output logic          valid_o,
  output logic          flush_o,
  output logic          misalign_o
);

  localparam int              PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int              CW    = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0]   QFULL = CW'(QDEPTH);
  localparam logic [31:0]     NOP   = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1, S_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1} state_t;
`endif

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic          r_imem_req;
  logic [31:0]   r_imem_addr;
  logic [CW-1:0] r_count;
  logic          r_drop;
  logic          r_flush;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_q_pc   [QDEPTH];
  logic [31:0]   r_q_inst [QDEPTH];

  state_t        w_state_nxt;
  logic [31:0]   w_fetch_pc_nxt;
  logic          w_req_nxt;
  logic [31:0]   w_addr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_drop_nxt;
  logic          w_flush_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic          w_valid;
  logic          w_halted;
  logic [31:0]   w_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;
  logic w_misalign_nxt;
  assign w_target   = redirect_pc;
  assign w_halted   = (r_state == S_HALT);
  assign misalign_o = r_misalign;
`else
  assign w_target   = redirect_pc & 32'hFFFF_FFFC;
  assign w_halted   = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign w_valid         = (r_count != {CW{1'b0}});
  assign valid_o         = w_valid;
  assign pc_o            = w_valid ? r_q_pc[r_rd_ptr]   : 32'h0000_0000;
  assign inst_o          = w_valid ? r_q_inst[r_rd_ptr] : NOP;
  assign flush_o         = r_flush;
  assign imem.imem_req   = r_imem_req;
  assign imem.imem_addr  = r_imem_addr;

  // Next-state, queue control and request look-ahead.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_drop_nxt     = r_drop;
    w_flush_nxt    = 1'b0;
    w_push         = 1'b0;
    w_clear        = 1'b0;
    w_pop          = w_valid && !stall;
`ifdef FETCH_MISALIGN_CHECK_EN
    w_misalign_nxt = r_misalign;
`endif
    case (r_state)
      S_RUN: begin
        // A raised request is accepted in the cycle it is visible.
        if (r_imem_req) w_state_nxt = S_WAIT;
        else            w_state_nxt = S_RUN;
      end
      S_WAIT: begin
        if (imem.imem_ready) begin
          w_state_nxt = S_RUN;
          if (r_drop) begin
            w_drop_nxt = 1'b0;
          end else begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      S_HALT: begin
        w_state_nxt = S_HALT;
        w_pop       = 1'b0;
      end
`endif
      default: w_state_nxt = S_RUN;
    endcase

    if (redirect && !w_halted) begin
      w_clear        = 1'b1;
      w_push         = 1'b0;
      w_pop          = 1'b0;
      w_flush_nxt    = 1'b1;
      w_fetch_pc_nxt = w_target;
      // Anything still in flight belongs to the old path.
      if ((r_state == S_WAIT && !imem.imem_ready) || (r_state == S_RUN && r_imem_req))
        w_drop_nxt = 1'b1;
      else
        w_drop_nxt = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (w_target[1:0] != 2'b00) begin
        w_state_nxt    = S_HALT;
        w_misalign_nxt = 1'b1;
        w_drop_nxt     = 1'b0;
      end else begin
        w_misalign_nxt = r_misalign;
      end
`endif
    end else begin
      w_clear = 1'b0;
    end

    if (w_clear)               w_count_nxt = {CW{1'b0}};
    else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
    else                       w_count_nxt = r_count;

    // Issue only with a free slot so the response can never overflow the queue.
    w_req_nxt  = (w_state_nxt == S_RUN) && (w_count_nxt < QFULL);
    w_addr_nxt = w_req_nxt ? w_fetch_pc_nxt : r_imem_addr;
  end

  // FSM state and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_fetch_pc  <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_count     <= {CW{1'b0}};
      r_drop      <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_imem_req  <= w_req_nxt;
      r_imem_addr <= w_addr_nxt;
      r_count     <= w_count_nxt;
      r_drop      <= w_drop_nxt;
      r_flush     <= w_flush_nxt;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_misalign_nxt;
  end
`endif

  // Fetch queue storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_pc[i]   <= 32'h0000_0000;
        r_q_inst[i] <= NOP;
      end
    end else if (w_clear) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_push) begin
        r_q_pc[r_wr_ptr]   <= r_imem_addr;
        r_q_inst[r_wr_ptr] <= imem.imem_rdata;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected addresses/words, monitors compare.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        flush_o;
  logic        misalign_o;

  fetch_stage_if mif();

  fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (mif),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .valid_o     (valid_o),
    .flush_o     (flush_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  int          mem_lat = 1;
  bit          mem_en  = 1'b1;
  bit          stray   = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: word at address A is 32'hC0DE_0000 | A[15:0], returned mem_lat cycles later.
  always @(negedge clk) begin
    if (rst) begin
      m_cnt          = 0;
      mif.imem_ready = 1'b0;
      mif.imem_rdata = 32'h0000_0000;
    end else if (!mem_en) begin
      mif.imem_ready = stray;
      mif.imem_rdata = 32'hDEAD_BEEF;
    end else begin
      mif.imem_ready = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mif.imem_ready = 1'b1;
          mif.imem_rdata = 32'hC0DE_0000 | {16'h0000, m_addr[15:0]};
        end
      end else if (mif.imem_req) begin
        m_addr = mif.imem_addr;
        m_cnt  = mem_lat;
      end
    end
  end

  // Request monitor.
  always @(negedge clk) begin
    if (!rst && mif.imem_req === 1'b1 && exp_addr_q.size() > 0)
      check("imem_addr", mif.imem_addr, exp_addr_q.pop_front());
  end

  // Output monitor: compares every head that the IF/ID buffer consumes.
  always @(negedge clk) begin
    if (!rst && valid_o === 1'b1 && !stall && !redirect && exp_pc_q.size() > 0) begin
      check("pc_o", pc_o, exp_pc_q.pop_front());
      check("inst_o", inst_o, exp_inst_q.pop_front());
    end
  end

  task automatic exp_word(input logic [31:0] pc, input logic [31:0] inst);
    exp_pc_q.push_back(pc);
    exp_inst_q.push_back(inst);
  endtask

  // Reset, then release; returns at the start of the first cycle after release.
  task automatic start(input int lat, input logic stall_v);
    @(posedge clk); #1;
    rst      = 1'b1;
    redirect = 1'b0;
    stall    = stall_v;
    mem_lat  = lat;
    mem_en   = 1'b1;
    stray    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_addr_q.size() > 0 || exp_pc_q.size() > 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    n_checks++;
    if (exp_addr_q.size() > 0 || exp_pc_q.size() > 0) begin
      n_errors++;
      $display("FAIL %s drain: %0d addrs and %0d words pending, required 0",
               name, exp_addr_q.size(), exp_pc_q.size());
      exp_addr_q.delete();
      exp_pc_q.delete();
      exp_inst_q.delete();
    end
  endtask

  initial begin
    logic [4:0] req_pat;
    logic [4:0] val_pat;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst imem_req", 32'(mif.imem_req), 32'd0);
    check("rst imem_addr", mif.imem_addr, 32'h0000_0000);
    check("rst pc_o", pc_o, 32'h0000_0000);
    check("rst inst_o", inst_o, 32'h0000_0013);
    check("rst valid_o", 32'(valid_o), 32'd0);
    check("rst flush_o", 32'(flush_o), 32'd0);
    check("rst misalign_o", 32'(misalign_o), 32'd0);

    // Straight-line fetch at latency 1: one instruction every 2 cycles.
    start(1, 1'b0);
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_word(32'h0, 32'hC0DE_0000);
    exp_word(32'h4, 32'hC0DE_0004);
    exp_word(32'h8, 32'hC0DE_0008);
    @(negedge clk);
    check("t1 c0 imem_req", 32'(mif.imem_req), 32'd0);
    req_pat = 5'b10101;
    val_pat = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1 imem_req pattern", 32'(mif.imem_req), 32'(req_pat[i]));
      check("t1 valid_o pattern", 32'(valid_o), 32'(val_pat[i]));
    end
    drain("t1", 40);

    // Stall with a full queue: requests stop, head holds.
    start(1, 1'b1);
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_word(32'h0, 32'hC0DE_0000);
    exp_word(32'h4, 32'hC0DE_0004);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i >= 5) begin
        check("t2 imem_req held low", 32'(mif.imem_req), 32'd0);
        check("t2 head pc_o", pc_o, 32'h0000_0000);
        check("t2 head inst_o", inst_o, 32'hC0DE_0000);
        check("t2 valid_o", 32'(valid_o), 32'd1);
      end
    end
    @(posedge clk); #1 stall = 1'b0;
    drain("t2", 40);

    // Redirect with a request outstanding at latency 3: old word dropped.
    start(3, 1'b0);
    exp_addr_q = '{32'h0, 32'h100, 32'h104};
    exp_word(32'h100, 32'hC0DE_0100);
    exp_word(32'h104, 32'hC0DE_0104);
    @(posedge clk); #1;
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    check("t3 flush_o before", 32'(flush_o), 32'd0);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t3 flush_o pulse", 32'(flush_o), 32'd1);
    @(negedge clk);
    check("t3 flush_o after", 32'(flush_o), 32'd0);
    check("t3 valid_o", 32'(valid_o), 32'd0);
    @(negedge clk);
    check("t3 valid_o after drop", 32'(valid_o), 32'd0);
    check("t3 imem_req", 32'(mif.imem_req), 32'd1);
    drain("t3", 60);

    // Redirect coinciding with imem_ready: that word is discarded.
    start(1, 1'b0);
    exp_addr_q = '{32'h0, 32'h200, 32'h204};
    exp_word(32'h200, 32'hC0DE_0200);
    exp_word(32'h204, 32'hC0DE_0204);
    @(posedge clk); #1;
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t4 flush_o", 32'(flush_o), 32'd1);
    check("t4 valid_o", 32'(valid_o), 32'd0);
    check("t4 imem_req", 32'(mif.imem_req), 32'd1);
    drain("t4", 40);

    // Redirect to the top word: fetch wraps to zero.
    start(1, 1'b0);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_addr_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    exp_word(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    exp_word(32'h0000_0000, 32'hC0DE_0000);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t5 imem_req", 32'(mif.imem_req), 32'd1);
    check("t5 flush_o", 32'(flush_o), 32'd1);
    drain("t5", 40);

    // Misaligned redirect target.
    start(1, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
`ifdef FETCH_MISALIGN_CHECK_EN
    @(posedge clk); #1 redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6 misalign_o", 32'(misalign_o), 32'd1);
      check("t6 imem_req", 32'(mif.imem_req), 32'd0);
      check("t6 valid_o", 32'(valid_o), 32'd0);
    end
`else
    exp_addr_q = '{32'h100, 32'h104};
    exp_word(32'h100, 32'hC0DE_0100);
    exp_word(32'h104, 32'hC0DE_0104);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t6 misalign_o", 32'(misalign_o), 32'd0);
    check("t6 imem_addr aligned", mif.imem_addr, 32'h0000_0100);
    drain("t6", 40);
`endif

    // Reset mid-transaction, then a stray imem_ready while idle.
    start(3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("t7 async imem_req", 32'(mif.imem_req), 32'd0);
    check("t7 async imem_addr", mif.imem_addr, 32'h0000_0000);
    check("t7 async valid_o", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0; stray = 1'b1;
    exp_addr_q = '{32'h0};
    exp_word(32'h0, 32'hC0DE_0000);
    @(negedge clk);
    check("t7 c0 valid_o", 32'(valid_o), 32'd0);
    @(posedge clk); #1 stray = 1'b0; mem_en = 1'b1;
    @(negedge clk);
    check("t7 stray ignored", 32'(valid_o), 32'd0);
    check("t7 imem_req", 32'(mif.imem_req), 32'd1);
    drain("t7", 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
